// File: rtl/hdmi_pkg.sv
// Shared HDMI/TMDS definitions: period mode encoding, period states and video preamble constants.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_CONTROL     = 2'd0,
    MODE_VIDEO_GUARD = 2'd1,
    MODE_VIDEO       = 2'd2,
    MODE_DATA_ISLAND = 2'd3
  } tmds_mode_t;

  typedef enum logic [1:0] {
    PERIOD_CONTROL,
    PERIOD_PREAMBLE,
    PERIOD_GUARD,
    PERIOD_VIDEO
  } video_period_t;

  localparam int         PREAMBLE_LEN       = 8;
  localparam int         GUARD_LEN          = 2;
  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
  localparam logic [3:0] CTL_IDLE           = 4'b0000;

endpackage

// File: rtl/timing_axis_counter.sv
// One video timing axis: wrapping position counter with sync-polarity and active-region decode.
module timing_axis_counter #(
  parameter int BIT_WIDTH = 10,
  parameter int ACTIVE    = 640,
  parameter int FRONT     = 16,
  parameter int SYNC      = 96,
  parameter int BACK      = 48,
  parameter bit SYNC_POL  = 1'b1,
  parameter int RESET_POS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  output logic [BIT_WIDTH-1:0] pos,
  output logic [BIT_WIDTH-1:0] pos_nxt,
  output logic                 sync,
  output logic                 active_nxt
);

  localparam int TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam int SYNC_START = ACTIVE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;
  localparam logic [BIT_WIDTH-1:0] LAST_POS = BIT_WIDTH'(TOTAL - 1);
  localparam logic [BIT_WIDTH-1:0] RST_POS  = BIT_WIDTH'(RESET_POS);

  logic last;
  logic sync_nxt;

  assign last = (pos == LAST_POS);

  always_comb begin
    pos_nxt = pos;
    if (adv) pos_nxt = last ? '0 : pos + 1'b1;
  end

  // Decode the upcoming position so the registered sync lines up with the registered counter.
  assign sync_nxt   = ((int'(pos_nxt) >= SYNC_START) && (int'(pos_nxt) < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign active_nxt = (int'(pos_nxt) < ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= RST_POS;
      sync <= ~SYNC_POL;
    end else begin
      pos  <= pos_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// Parametrised HDMI video timing: coordinates, syncs, DE and per-cycle TMDS period mode.
// Define HDMI_VIDEO_PREAMBLE_EN for video preamble + leading guard band; undefined gives DVI-only periods.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                 CLK_PIXEL,
  input  logic                 RESET_N,
  output logic [BIT_WIDTH-1:0] cx,
  output logic [BIT_WIDTH-1:0] cy,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [1:0]           mode,
  output logic [5:0]           ctrl,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [BIT_WIDTH-1:0] H_LAST = BIT_WIDTH'(H_TOTAL - 1);

  if (H_TOTAL - H_ACTIVE < 12) begin : g_bad_hblank
    $error("hdmi_video_timing: horizontal blanking too short for preamble and guard band");
  end
  if ((H_TOTAL > (1 << BIT_WIDTH)) || (V_TOTAL > (1 << BIT_WIDTH))) begin : g_bad_width
    $error("hdmi_video_timing: BIT_WIDTH too small for H_TOTAL/V_TOTAL");
  end

  logic [BIT_WIDTH-1:0] cx_nxt, cy_nxt;
  logic                 h_act_nxt, v_act_nxt, h_wrap, de_nxt;
  video_period_t        period_q, period_d;
  logic [3:0]           ctl_bits;

  assign h_wrap = (cx == H_LAST);

  timing_axis_counter #(
    .BIT_WIDTH(BIT_WIDTH), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(HSYNC_POL), .RESET_POS(0)
  ) u_h_axis (
    .clk(CLK_PIXEL), .rst_n(RESET_N), .adv(1'b1),
    .pos(cx), .pos_nxt(cx_nxt), .sync(hsync), .active_nxt(h_act_nxt)
  );

  // Vertical axis steps only on the horizontal wrap, so vsync changes exactly at cx==0.
  timing_axis_counter #(
    .BIT_WIDTH(BIT_WIDTH), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(VSYNC_POL), .RESET_POS(V_ACTIVE)
  ) u_v_axis (
    .clk(CLK_PIXEL), .rst_n(RESET_N), .adv(h_wrap),
    .pos(cy), .pos_nxt(cy_nxt), .sync(vsync), .active_nxt(v_act_nxt)
  );

  assign de_nxt = h_act_nxt & v_act_nxt;

`ifdef HDMI_VIDEO_PREAMBLE_EN
  localparam logic [BIT_WIDTH-1:0] V_LAST = BIT_WIDTH'(V_TOTAL - 1);
  localparam int GUARD_START    = H_TOTAL - GUARD_LEN;
  localparam int PREAMBLE_START = GUARD_START - PREAMBLE_LEN;

  logic pre_active_nxt;
  // A line is pre-active when its successor carries video; its tail gets preamble then guard.
  assign pre_active_nxt = (int'(cy_nxt) <= V_ACTIVE - 2) || (cy_nxt == V_LAST);
`endif

  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      period_q    <= PERIOD_CONTROL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      period_q    <= period_d;
      de          <= de_nxt;
      line_start  <= (cx_nxt == '0);
      frame_start <= (cx_nxt == '0) && (cy_nxt == '0);
    end
  end

  always_comb begin
    period_d = PERIOD_CONTROL;
    if (de_nxt) begin
      period_d = PERIOD_VIDEO;
    end
`ifdef HDMI_VIDEO_PREAMBLE_EN
    else if (pre_active_nxt && (int'(cx_nxt) >= GUARD_START)) begin
      period_d = PERIOD_GUARD;
    end else if (pre_active_nxt && (int'(cx_nxt) >= PREAMBLE_START)) begin
      period_d = PERIOD_PREAMBLE;
    end
`endif
  end

  always_comb begin
    mode     = MODE_CONTROL;
    ctl_bits = CTL_IDLE;
    case (period_q)
      PERIOD_VIDEO:    mode     = MODE_VIDEO;
      PERIOD_GUARD:    mode     = MODE_VIDEO_GUARD;
      PERIOD_PREAMBLE: ctl_bits = CTL_VIDEO_PREAMBLE;
      default:         mode     = MODE_CONTROL;
    endcase
  end

  assign ctrl = {ctl_bits, vsync, hsync};

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: three parameter sets checked cycle-by-cycle against a position model.
module tb_hdmi_video_timing;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  localparam int T_FRAME = 37599;

  logic [9:0]  cx_d, cy_d;
  logic [10:0] cx_h, cy_h;
  logic [4:0]  cx_s, cy_s;
  logic        hs_d, vs_d, de_d, ls_d, fs_d;
  logic        hs_h, vs_h, de_h, ls_h, fs_h;
  logic        hs_s, vs_s, de_s, ls_s, fs_s;
  logic [1:0]  mode_d, mode_h, mode_s;
  logic [5:0]  ctrl_d, ctrl_h, ctrl_s;

  hdmi_video_timing u_def (
    .CLK_PIXEL(clk), .RESET_N(rst_n), .cx(cx_d), .cy(cy_d), .hsync(hs_d), .vsync(vs_d),
    .de(de_d), .mode(mode_d), .ctrl(ctrl_d), .line_start(ls_d), .frame_start(fs_d)
  );

  hdmi_video_timing #(
    .BIT_WIDTH(11), .H_ACTIVE(1280), .H_FRONT(110), .H_SYNC(40), .H_BACK(220),
    .V_ACTIVE(720), .V_FRONT(5), .V_SYNC(5), .V_BACK(20), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_hd (
    .CLK_PIXEL(clk), .RESET_N(rst_n), .cx(cx_h), .cy(cy_h), .hsync(hs_h), .vsync(vs_h),
    .de(de_h), .mode(mode_h), .ctrl(ctrl_h), .line_start(ls_h), .frame_start(fs_h)
  );

  hdmi_video_timing #(
    .BIT_WIDTH(5), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(7),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_sm (
    .CLK_PIXEL(clk), .RESET_N(rst_n), .cx(cx_s), .cy(cy_s), .hsync(hs_s), .vsync(vs_s),
    .de(de_s), .mode(mode_s), .ctrl(ctrl_s), .line_start(ls_s), .frame_start(fs_s)
  );

  // Expected outputs t clock edges after reset release, from raster position arithmetic.
  function automatic logic [44:0] model(input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp, input int t_in);
    int ht, vt, x, y;
    logic h, v, d, ls, fs;
    logic [1:0] m;
    logic [3:0] c;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = t_in % ht;
    y  = (va + t_in / ht) % vt;
    h  = (x >= ha + hf && x < ha + hf + hs) ? hp : !hp;
    v  = (y >= va + vf && y < va + vf + vs) ? vp : !vp;
    d  = (x < ha) && (y < va);
    m  = 2'd0;
    c  = 4'd0;
    if (d) m = 2'd2;
`ifdef HDMI_VIDEO_PREAMBLE_EN
    else if (((y + 1 < va) || (y == vt - 1)) && x >= ht - 2) m = 2'd1;
    else if (((y + 1 < va) || (y == vt - 1)) && x >= ht - 10) c = 4'b0001;
`endif
    ls = (t_in != 0) && (x == 0);
    fs = ls && (y == 0);
    return {16'(x), 16'(y), h, v, d, m, c, v, h, ls, fs};
  endfunction

  function automatic logic [44:0] exp_def(input int t_in);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, t_in);
  endfunction
  function automatic logic [44:0] exp_hd(input int t_in);
    return model(1280, 110, 40, 220, 720, 5, 5, 20, 1'b0, 1'b0, t_in);
  endfunction
  function automatic logic [44:0] exp_sm(input int t_in);
    return model(8, 2, 3, 7, 4, 1, 2, 1, 1'b1, 1'b0, t_in);
  endfunction

  function automatic logic [44:0] obs_def();
    return {16'(cx_d), 16'(cy_d), hs_d, vs_d, de_d, mode_d, ctrl_d, ls_d, fs_d};
  endfunction
  function automatic logic [44:0] obs_hd();
    return {16'(cx_h), 16'(cy_h), hs_h, vs_h, de_h, mode_h, ctrl_h, ls_h, fs_h};
  endfunction
  function automatic logic [44:0] obs_sm();
    return {16'(cx_s), 16'(cy_s), hs_s, vs_s, de_s, mode_s, ctrl_s, ls_s, fs_s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cx_d !== 10'd0 || cy_d !== 10'd480) begin
      failures++; $display("FAIL reset_pos_def got cx=%0d cy=%0d want cx=0 cy=480", cx_d, cy_d);
    end
    checks++;
    if ({hs_d, vs_d, de_d, mode_d, ctrl_d, ls_d, fs_d} !== 13'b0_0_0_00_000000_0_0) begin
      failures++; $display("FAIL reset_out_def got %b want 0000000000000",
                           {hs_d, vs_d, de_d, mode_d, ctrl_d, ls_d, fs_d});
    end
    checks++;
    if (cx_h !== 11'd0 || cy_h !== 11'd720 || hs_h !== 1'b1 || vs_h !== 1'b1 || ctrl_h !== 6'b000011) begin
      failures++; $display("FAIL reset_hd got cx=%0d cy=%0d hs=%b vs=%b ctrl=%b want 0 720 1 1 000011",
                           cx_h, cy_h, hs_h, vs_h, ctrl_h);
    end
    checks++;
    if (obs_sm() !== exp_sm(0) || ctrl_s !== 6'b000010) begin
      failures++; $display("FAIL reset_sm got %h want %h", obs_sm(), exp_sm(0));
    end
  endtask

  task automatic test_frame_timing();
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    int hd_cnt = 0, hd_first = -1, hd_last = -1;
    int vs_lines = 0, vs_first = -1, de_cnt = 0, fs_cnt = 0;
    int fs_sm_cnt = 0, de_sm_win = 0, guard_cnt = 0, ctl_cnt = 0;
    logic [5:0] exp_mc;
    rst_n = 1'b1;
    t = 0;
    for (int i = 1; i <= T_FRAME; i++) begin
      @(posedge clk); t++; @(negedge clk);
      checks++;
      if (obs_def() !== exp_def(t)) begin
        failures++; $display("FAIL cycle_def t=%0d got=%h want=%h", t, obs_def(), exp_def(t));
      end
      checks++;
      if (obs_hd() !== exp_hd(t)) begin
        failures++; $display("FAIL cycle_hd t=%0d got=%h want=%h", t, obs_hd(), exp_hd(t));
      end
      checks++;
      if (obs_sm() !== exp_sm(t)) begin
        failures++; $display("FAIL cycle_sm t=%0d got=%h want=%h", t, obs_sm(), exp_sm(t));
      end
      if (t < 800 && hs_d) begin
        hs_cnt++; if (hs_first < 0) hs_first = int'(cx_d); hs_last = int'(cx_d);
      end
      if (t < 1650 && !hs_h) begin
        hd_cnt++; if (hd_first < 0) hd_first = int'(cx_h); hd_last = int'(cx_h);
      end
      if (vs_d && cx_d == 10'd0) begin
        vs_lines++; if (vs_first < 0) vs_first = int'(cy_d);
      end
      if (de_d) de_cnt++;
      if (fs_d) fs_cnt++;
      if (fs_s) fs_sm_cnt++;
      if (t >= 80 && t < 240 && de_s) de_sm_win++;
      if (mode_d == 2'd1 || mode_h == 2'd1 || mode_s == 2'd1) guard_cnt++;
      if (ctrl_d[5:2] != 4'd0 || ctrl_h[5:2] != 4'd0 || ctrl_s[5:2] != 4'd0) ctl_cnt++;
      if (t == 800) begin
        checks++;
        if ({cx_d, cy_d, ls_d} !== {10'd0, 10'd481, 1'b1}) begin
          failures++; $display("FAIL hwrap_def got cx=%0d cy=%0d ls=%b want 0 481 1", cx_d, cy_d, ls_d);
        end
      end
      if (t == 1650) begin
        checks++;
        if ({cx_h, cy_h} !== {11'd0, 11'd721}) begin
          failures++; $display("FAIL hwrap_hd got cx=%0d cy=%0d want 0 721", cx_h, cy_h);
        end
      end
      if (t >= 35990 && t <= 36000) begin
        exp_mc = 6'b00_0000;
`ifdef HDMI_VIDEO_PREAMBLE_EN
        if (t <= 35997) exp_mc = 6'b00_0001;
        else if (t <= 35999) exp_mc = 6'b01_0000;
`endif
        if (t == 36000) exp_mc = 6'b10_0000;
        checks++;
        if ({mode_d, ctrl_d[5:2]} !== exp_mc) begin
          failures++; $display("FAIL preamble_def cx=%0d cy=%0d got mode/ctl=%b want %b",
                               cx_d, cy_d, {mode_d, ctrl_d[5:2]}, exp_mc);
        end
      end
      if (t == 36000) begin
        checks++;
        if ({cx_d, cy_d, de_d, fs_d} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
          failures++; $display("FAIL vwrap_def got cx=%0d cy=%0d de=%b fs=%b want 0 0 1 1", cx_d, cy_d, de_d, fs_d);
        end
      end
    end
    checks++;
    if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      failures++; $display("FAIL hsync_def got n=%0d first=%0d last=%0d want 96 656 751", hs_cnt, hs_first, hs_last);
    end
    checks++;
    if (hd_cnt != 40 || hd_first != 1390 || hd_last != 1429) begin
      failures++; $display("FAIL hsync_hd got n=%0d first=%0d last=%0d want 40 1390 1429", hd_cnt, hd_first, hd_last);
    end
    checks++;
    if (vs_lines != 2 || vs_first != 490) begin
      failures++; $display("FAIL vsync_def got lines=%0d first=%0d want 2 490", vs_lines, vs_first);
    end
    checks++;
    if (de_cnt != 1280 || fs_cnt != 1) begin
      failures++; $display("FAIL de_fs_def got de=%0d fs=%0d want 1280 1", de_cnt, fs_cnt);
    end
    checks++;
    if (fs_sm_cnt != (T_FRAME - 80) / 160 + 1 || de_sm_win != 32) begin
      failures++; $display("FAIL frame_sm got fs=%0d de=%0d want %0d 32", fs_sm_cnt, de_sm_win, (T_FRAME - 80) / 160 + 1);
    end
`ifdef HDMI_VIDEO_PREAMBLE_EN
    checks++;
    if (guard_cnt == 0 || ctl_cnt == 0) begin
      failures++; $display("FAIL hdmi_periods got guard=%0d preamble=%0d want both nonzero", guard_cnt, ctl_cnt);
    end
`else
    checks++;
    if (guard_cnt != 0 || ctl_cnt != 0) begin
      failures++; $display("FAIL dvi_periods got guard=%0d preamble=%0d want 0 0", guard_cnt, ctl_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    int first_de = -1;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); t++; @(negedge clk);
      checks++;
      if (obs_def() !== exp_def(t)) begin
        failures++; $display("FAIL seek_def t=%0d got=%h want=%h", t, obs_def(), exp_def(t));
      end
      if (cx_d == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL seek_cx300 got timeout want cx=300");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_def() !== exp_def(0) || obs_hd() !== exp_hd(0) || obs_sm() !== exp_sm(0)) begin
      failures++; $display("FAIL async_reset got %h %h %h want %h %h %h",
                           obs_def(), obs_hd(), obs_sm(), exp_def(0), exp_hd(0), exp_sm(0));
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); t++; @(negedge clk);
      checks++;
      if (obs_sm() !== exp_sm(t)) begin
        failures++; $display("FAIL restart_sm t=%0d got=%h want=%h", t, obs_sm(), exp_sm(t));
      end
      checks++;
      if (obs_def() !== exp_def(t)) begin
        failures++; $display("FAIL restart_def t=%0d got=%h want=%h", t, obs_def(), exp_def(t));
      end
      if (de_s && first_de < 0) first_de = t;
    end
    checks++;
    if (first_de != 80) begin
      failures++; $display("FAIL first_video_sm got t=%0d want 80", first_de);
    end
  endtask

  task automatic test_random_resets();
    int n, off, hold;
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 500));
      for (int i = 0; i < n; i++) begin
        @(posedge clk); t++; @(negedge clk);
        checks++;
        if (obs_sm() !== exp_sm(t)) begin
          failures++; $display("FAIL rand_sm t=%0d got=%h want=%h", t, obs_sm(), exp_sm(t));
        end
        checks++;
        if (obs_hd() !== exp_hd(t)) begin
          failures++; $display("FAIL rand_hd t=%0d got=%h want=%h", t, obs_hd(), exp_hd(t));
        end
      end
      off  = int'($urandom_range(1, 3));
      hold = int'($urandom_range(1, 3));
      #(off) rst_n = 1'b0;
      #1;
      checks++;
      if (obs_def() !== exp_def(0) || obs_hd() !== exp_hd(0) || obs_sm() !== exp_sm(0)) begin
        failures++; $display("FAIL rand_reset k=%0d got %h %h %h want %h %h %h", k,
                             obs_def(), obs_hd(), obs_sm(), exp_def(0), exp_hd(0), exp_sm(0));
      end
      repeat (hold) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs_sm() !== exp_sm(0)) begin
        failures++; $display("FAIL rand_hold k=%0d got=%h want=%h", k, obs_sm(), exp_sm(0));
      end
      rst_n = 1'b1;
      t = 0;
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_mid_reset();
    test_random_resets();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
